// File: rtl/serial_and16.sv
// Bit-serial AND engine: one 2-input AND gate evaluated once per BUSY cycle, LSB first.
// Optional per-bit stream outputs are enabled by defining SERIAL_AND16_BITSTREAM_EN.
module serial_and16 #(
  parameter int WIDTH = 16  // legal range 2..64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in0,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef SERIAL_AND16_BITSTREAM_EN
  output logic             bit_out,
  output logic             bit_valid,
`endif
  output logic [1:0]       o_dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // in_ready depends only on state, so out_ready never reaches in_ready within a cycle.

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_r;
  logic [CW-1:0]    r_cnt;
  logic             w_bit;
  logic             w_accept;

  // The single gate of the engine.
  assign w_bit    = r_a[0] & r_b[0];
  assign w_accept = in_valid && (r_state == IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: if (in_valid) w_next_state = BUSY;
      BUSY: if (r_cnt == LAST_BIT) w_next_state = DONE;
      DONE: if (out_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a   <= '0;
      r_b   <= '0;
      r_r   <= '0;
      r_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_a   <= in1;
        r_b   <= in0;
        r_cnt <= '0;
      end else if (r_state == BUSY) begin
        r_r   <= {w_bit, r_r[WIDTH-1:1]};
        r_a   <= r_a >> 1;
        r_b   <= r_b >> 1;
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // out tracks r, which is frozen outside BUSY, so the last result persists in IDLE.
  assign in_ready    = (r_state == IDLE);
  assign out_valid   = (r_state == DONE);
  assign out         = r_r;
  assign o_dbg_state = r_state;

`ifdef SERIAL_AND16_BITSTREAM_EN
  assign bit_valid = (r_state == BUSY);
  assign bit_out   = (r_state == BUSY) & w_bit;
`endif

endmodule

// File: tb/tb_serial_and16.sv
// Self-checking bench for serial_and16: directed cases from the test plan plus random operands.
// Define SERIAL_AND16_BITSTREAM_EN for both files to exercise the bit stream outputs.
module tb_serial_and16;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in1;
  logic [W-1:0] in0;
  logic [W-1:0] out;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   dbg_state;
`ifdef SERIAL_AND16_BITSTREAM_EN
  logic         bit_out;
  logic         bit_valid;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic [W-1:0] exp_q[$];

  serial_and16 #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in1        (in1),
    .in0        (in0),
    .out        (out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
`ifdef SERIAL_AND16_BITSTREAM_EN
    .bit_out    (bit_out),
    .bit_valid  (bit_valid),
`endif
    .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every completed output handshake must match the oldest expected result.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_out", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check_val("result", out, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Returns the cycle number of the accepting edge; keep_valid leaves in_valid high afterwards.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] e,
                      input bit keep_valid, output int t_acc);
    @(posedge clk); #1;
    in1 = a;
    in0 = b;
    in_valid = 1'b1;
    t_acc = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin
        t_acc = cyc + 1;
        break;
      end
    end
    if (t_acc < 0) check_val("accept_timeout", 0, 1);
    else exp_q.push_back(e);
    @(posedge clk); #1;
    if (!keep_valid) in_valid = 1'b0;
  endtask

  task automatic wait_out(output int t);
    t = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (out_valid) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) check_val("out_valid_timeout", 0, 1);
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    check_val("drain", exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t0, t1;
    logic [W-1:0] ra, rb;

    reset = 1'b1;
    in_valid = 1'b0;
    in1 = '0;
    in0 = '0;
    out_ready = 1'b1;
    #3;
    check_val("rst_in_ready", in_ready, 1);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_out", out, 0);
    check_val("rst_state", dbg_state, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Latency, value, single-cycle pulse
    send(16'hFFFF, 16'h1234, 16'h1234, 1'b0, t0);
    wait_out(t1);
    check_val("latency", t1 - t0, 16);
    check_val("out_value", out, 16'h1234);
    @(negedge clk);
    check_val("pulse_width", out_valid, 0);
    check_val("in_ready_back", in_ready, 1);

    // Back-to-back with in_valid held high
    send(16'hAAAA, 16'h5555, 16'h0000, 1'b1, t0);
    send(16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, t1);
    check_val("accept_spacing", t1 - t0, 18);
    wait_drain();

    // Backpressure: DONE held while out_ready is low
    out_ready = 1'b0;
    send(16'hFFFF, 16'h1234, 16'h1234, 1'b0, t0);
    wait_out(t1);
    for (int i = 0; i < 5; i++) begin
      check_val("hold_out", out, 16'h1234);
      check_val("hold_valid", out_valid, 1);
      check_val("hold_in_ready", in_ready, 0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_val("idle_after_release", dbg_state, 0);
    check_val("in_ready_after_release", in_ready, 1);
    wait_drain();

    // Reset mid-BUSY discards the operation
    send(16'hFFFF, 16'h1234, 16'h1234, 1'b0, t0);
    repeat (6) @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    #1;
    check_val("abort_out_valid", out_valid, 0);
    check_val("abort_out", out, 0);
    check_val("abort_in_ready", in_ready, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    send(16'h00FF, 16'h0F0F, 16'h000F, 1'b0, t0);
    wait_drain();

    // in_valid during BUSY is ignored
    send(16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0, t0);
    repeat (3) @(posedge clk);
    #1;
    in1 = '0;
    in0 = '0;
    in_valid = 1'b1;
    @(negedge clk);
    check_val("busy_in_ready", in_ready, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_drain();
    repeat (25) @(negedge clk);
    check_val("idle_after_ignore", dbg_state, 0);
    check_val("out_persists", out, 16'hFFFF);

    // Random operands
    for (int i = 0; i < 6; i++) begin
      ra = W'($urandom_range(0, 16'hFFFF));
      rb = W'($urandom_range(0, 16'hFFFF));
      send(ra, rb, ra & rb, 1'b0, t0);
      wait_drain();
    end

`ifdef SERIAL_AND16_BITSTREAM_EN
    send(16'h8001, 16'hFFFF, 16'h8001, 1'b0, t0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check_val("bit_valid", bit_valid, 1);
      check_val("bit_out", bit_out, (i == 0 || i == 15) ? 1 : 0);
    end
    @(negedge clk);
    check_val("bit_valid_done", bit_valid, 0);
    check_val("bit_out_done", bit_out, 0);
    wait_drain();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_and16.md
# serial_and16

Bit-serial 16-bit AND engine for the gates library. Accepts two 16-bit operands through a valid/ready handshake, evaluates the AND one bit per clock with a single 2-input AND gate (LSB first), and returns the assembled 16-bit word through a second valid/ready handshake. It is the time-multiplexed counterpart of the parallel 16-way AND: one gate instead of sixteen, at the cost of WIDTH cycles of latency. It sits between an operand producer and a result consumer in the datapath test fabric.

## Interface
- WIDTH, 16, operand/result width; legal range 2..64; counter width is $clog2(WIDTH+1)
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept an operand pair
- in1  input  WIDTH  operand 1
- in0  input  WIDTH  operand 0
- out  output  WIDTH  result in1 & in0; meaningful only while out_valid=1
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result

## Operation
- States: IDLE, BUSY, DONE; state register, operand shift registers a/b, result shift register r, bit counter cnt.
- IDLE: in_ready=1 (combinational, in_ready = state==IDLE). On in_valid&in_ready at an edge: a<=in1, b<=in0, cnt<=0, state<=BUSY.
- BUSY: each edge: r <= {a[0]&b[0], r[WIDTH-1:1]}; a<=a>>1; b<=b>>1; cnt<=cnt+1. Edge on which cnt==WIDTH-1: state<=DONE.
- DONE: out_valid=1, out=r, held stable until handshake. On out_valid&out_ready: state<=IDLE.
- in_valid outside IDLE is ignored; in1/in0 sampled only at the accept edge; later operand changes have no effect.
- out keeps the last result after returning to IDLE; out_valid=0 there.
- Exactly one gate evaluation per BUSY cycle; no parallel shortcut.

## Timing
- Reset (async, immediate): state=IDLE, in_ready=1, out_valid=0, out=0, cnt=0, a=b=r=0.
- Reset asserted mid-BUSY or mid-DONE aborts the operation; the result is discarded, no out_valid pulse.
- Accept at edge t0 -> BUSY for cycles t0+1..t0+WIDTH -> out_valid=1 from edge t0+WIDTH.
- out_ready=1 while out_valid: IDLE after edge t0+WIDTH+1; next accept earliest at edge t0+WIDTH+2. Max throughput one result per WIDTH+2 cycles.
- out_ready low: stay in DONE indefinitely, out and out_valid constant.
- out_ready high before out_valid has no effect; no combinational path from out_ready to in_ready within the same cycle.

## Configuration
- SERIAL_AND16_BITSTREAM_EN defined: two extra output ports, bit_out (1) and bit_valid (1). During each BUSY cycle bit_valid=1 and bit_out=a[0]&b[0], the bit being shifted in at the end of that cycle (LSB first, WIDTH pulses per operation); both 0 in IDLE/DONE and at reset.
- Undefined: ports absent; all other behaviour identical.

## Test plan
- Reset then in1=16'hFFFF, in0=16'h1234, out_ready=1 -> out_valid rises exactly 16 cycles after accept, out=16'h1234, one-cycle pulse, in_ready back 1 cycle later.
- in1=16'hAAAA, in0=16'h5555 then in1=16'hF0F0, in0=16'h3C3C back-to-back, in_valid held high -> results 16'h0000 then 16'h3030, accepts spaced 18 cycles.
- out_ready held 0 for 5 cycles after out_valid -> out=16'h1234 and out_valid=1 stable all 5 cycles, in_ready=0; release -> IDLE next edge.
- Assert reset 7 cycles into BUSY -> immediately out_valid=0, out=0, in_ready=1; following op 16'h00FF & 16'h0F0F gives 16'h000F.
- in_valid pulsed with 16'h0000/16'h0000 during BUSY of 16'hFFFF&16'hFFFF -> ignored, out=16'hFFFF.
- With SERIAL_AND16_BITSTREAM_EN, 16'h8001 & 16'hFFFF -> bit_valid high 16 cycles, bit_out sequence 1,0x14,1.
